run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 25 ++
 rtl/run_ctrl_cycle_ctr.sv | 42 ++++
 rtl/run_ctrl.sv | 129 ++++++++++++
 tb/tb_run_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM states,
// the per-program start address table and datapath widths.
package run_ctrl_pkg;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int PC_W   = 12;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Core entry address for each selectable program.
  localparam logic [PC_W-1:0] START_PC [4] = '{12'h010, 12'h200, 12'h400, 12'h800};

  function automatic logic [PC_W-1:0] start_pc_of(input logic [SEL_W-1:0] sel);
    return START_PC[sel];
  endfunction

endpackage

// File: rtl/run_ctrl_cycle_ctr.sv
// Run-cycle counter: synchronous clear, count enable, saturation at
// all-ones and an equality flag against the supplied limit.
module run_ctrl_cycle_ctr
  import run_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == limit);

endmodule

// File: rtl/run_ctrl.sv
// Bench-side run controller: starts a core program on request, bounds the
// run length, reports completion/timeout and arbitrates the data memory
// between the host (when idle/done) and the core (while starting/running).
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [15:0] MAX_CYCLES = 16'd60000
) (
  input  logic        clk,
  input  logic        init,
  input  logic        req,
  input  logic [1:0]  prog_sel,
  output logic        ack,
  output logic        timeout,
  output logic        core_start,
  output logic        core_run,
  output logic [11:0] start_pc,
  input  logic        core_halt,
  output logic [15:0] cycle_count,
  input  logic        host_wen,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  input  logic        core_wen,
  input  logic [7:0]  core_addr,
  input  logic [7:0]  core_wdata,
  output logic        mem_wen,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        host_grant
);

  // Last count value allowed before the run is forced to end.
  localparam logic [CNT_W-1:0] LIMIT = MAX_CYCLES - 16'd1;

  state_e           state_d, state_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic             timeout_d, timeout_q;
  logic             ctr_clr, ctr_en, ctr_at_limit;

  run_ctrl_cycle_ctr u_cycle_ctr (
    .clk      (clk),
    .rst      (init),
    .clr      (ctr_clr),
    .en       (ctr_en),
    .limit    (LIMIT),
    .count    (cycle_count),
    .at_limit (ctr_at_limit)
  );

  // Next-state logic; a halt always beats the limit in the same cycle.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_START;
          sel_d   = prog_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        ctr_clr   = 1'b1;
        timeout_d = 1'b0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (core_halt) begin
          ctr_en    = 1'b1;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (ctr_at_limit) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; init aborts any run immediately.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign ack        = (state_q == ST_DONE);
  assign core_start = (state_q == ST_START);
  assign core_run   = (state_q == ST_RUN);
  assign timeout    = timeout_q;
  assign start_pc   = start_pc_of(sel_q);
  assign host_grant = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // Memory port mux: only the current owner reaches memory; writes blocked during init.
  always_comb begin
    if (host_grant) begin
      mem_wen   = host_wen & ~init;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_wen   = core_wen & ~init;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the run controller.
module tb_run_ctrl;

  localparam logic [15:0] MAXC = 16'd20;
  localparam logic [11:0] PC_TBL [4] = '{12'h010, 12'h200, 12'h400, 12'h800};

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  prog_sel = 2'd0;
  logic        core_halt = 1'b0;
  logic        host_wen = 1'b0, core_wen = 1'b0;
  logic [7:0]  host_addr = 8'd0, host_wdata = 8'd0, core_addr = 8'd0, core_wdata = 8'd0;
  logic        ack, timeout, core_start, core_run, mem_wen, host_grant;
  logic [11:0] start_pc;
  logic [15:0] cycle_count;
  logic [7:0]  mem_addr, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  run_ctrl #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .init(init), .req(req), .prog_sel(prog_sel),
    .ack(ack), .timeout(timeout), .core_start(core_start), .core_run(core_run),
    .start_pc(start_pc), .core_halt(core_halt), .cycle_count(cycle_count),
    .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
    .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .host_grant(host_grant)
  );

  always #5 clk = ~clk;

  // Behavioural model: m_phase 0 idle, 1 start pulse, 2 running, 3 finished.
  int         m_phase = 0;
  int         m_cnt   = 0;
  int         m_sel   = 0;
  bit         m_to    = 1'b0;

  // Model advances on each clock edge from the rules of a run; init resets it at once.
  always @(posedge clk or posedge init) begin
    if (init) begin
      m_phase <= 0; m_cnt <= 0; m_sel <= 0; m_to <= 1'b0;
    end else begin
      if (m_phase == 0) begin
        if (req) begin m_phase <= 1; m_sel <= int'(prog_sel); end
      end else if (m_phase == 1) begin
        m_phase <= 2; m_cnt <= 0; m_to <= 1'b0;
      end else if (m_phase == 2) begin
        if (core_halt) begin
          m_phase <= 3; m_to <= 1'b0; m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else if (m_cnt == int'(MAXC) - 1) begin
          m_phase <= 3; m_to <= 1'b1;
        end else begin
          m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
      end else begin
        if (!req) m_phase <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit own_host;
      own_host = (m_phase == 0) || (m_phase == 3);
      chk("ack",        {31'd0, ack},        {31'd0, m_phase == 3});
      chk("core_start", {31'd0, core_start}, {31'd0, m_phase == 1});
      chk("core_run",   {31'd0, core_run},   {31'd0, m_phase == 2});
      chk("host_grant", {31'd0, host_grant}, {31'd0, own_host});
      chk("timeout",    {31'd0, timeout},    {31'd0, m_to});
      chk("cycle_count", {16'd0, cycle_count}, m_cnt);
      chk("start_pc",   {20'd0, start_pc},   {20'd0, PC_TBL[m_sel]});
      chk("mem_wen",    {31'd0, mem_wen},
          {31'd0, !init && (own_host ? host_wen : core_wen)});
      chk("mem_addr",   {24'd0, mem_addr},   {24'd0, own_host ? host_addr : core_addr});
      chk("mem_wdata",  {24'd0, mem_wdata},  {24'd0, own_host ? host_wdata : core_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop if the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    init   = 1'b0;
    cmp_en = 1'b1;
    chk("rst_ack",   {31'd0, ack},      32'd0);
    chk("rst_count", {16'd0, cycle_count}, 32'd0);
    chk("rst_grant", {31'd0, host_grant}, 32'd1);

    // Host write while idle reaches memory.
    host_wen = 1'b1; host_addr = 8'h40; host_wdata = 8'hA5;
    #1;
    chk("idle_host_wen",  {31'd0, mem_wen},  32'd1);
    chk("idle_host_addr", {24'd0, mem_addr}, 32'h40);
    chk("idle_host_data", {24'd0, mem_wdata}, 32'hA5);

    // Program 2 run halted on its 10th RUN cycle.
    req = 1'b1; prog_sel = 2'd2;
    tick();
    chk("start_pulse", {31'd0, core_start}, 32'd1);
    chk("start_pc2",   {20'd0, start_pc},   32'h400);
    tick();
    chk("run_count0",  {16'd0, cycle_count}, 32'd0);
    // Host write in RUN is dropped; core write passes through.
    host_wen = 1'b1; core_wen = 1'b0;
    #1;
    chk("run_host_drop", {31'd0, mem_wen}, 32'd0);
    core_wen = 1'b1; core_addr = 8'h12; core_wdata = 8'h34;
    #1;
    chk("run_core_wen",  {31'd0, mem_wen},  32'd1);
    chk("run_core_addr", {24'd0, mem_addr}, 32'h12);
    host_wen = 1'b0; core_wen = 1'b0;
    repeat (9) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("halt_ack",     {31'd0, ack},      32'd1);
    chk("halt_count",   {16'd0, cycle_count}, 32'd10);
    chk("halt_timeout", {31'd0, timeout},  32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("done_hold", {31'd0, ack}, 32'd1);
    end
    req = 1'b0;
    tick();
    chk("done_release", {31'd0, ack}, 32'd0);

    // Limit-forced timeout.
    req = 1'b1; prog_sel = 2'd1;
    tick(); tick();
    req = 1'b0;
    repeat (20) tick();
    chk("to_ack",     {31'd0, ack},      32'd1);
    chk("to_timeout", {31'd0, timeout},  32'd1);
    chk("to_count",   {16'd0, cycle_count}, 32'd19);
    tick();

    // Halt coincident with the limit cycle: halt wins.
    req = 1'b1; prog_sel = 2'd3;
    tick(); tick();
    req = 1'b0;
    repeat (19) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("tie_ack",     {31'd0, ack},     32'd1);
    chk("tie_timeout", {31'd0, timeout}, 32'd0);
    tick();

    // init mid-run aborts with no ack; held req restarts.
    req = 1'b1; prog_sel = 2'd0;
    tick(); tick();
    repeat (3) tick();
    init = 1'b1;
    #1;
    chk("abort_ack",   {31'd0, ack},      32'd0);
    chk("abort_run",   {31'd0, core_run}, 32'd0);
    chk("abort_count", {16'd0, cycle_count}, 32'd0);
    tick();
    init = 1'b0;
    tick();
    chk("restart_pulse", {31'd0, core_start}, 32'd1);
    req = 1'b0;

    // Randomized traffic checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      req        = ($urandom_range(0, 9) < 7);
      prog_sel   = 2'($urandom_range(0, 3));
      core_halt  = ($urandom_range(0, 29) == 0);
      init       = ($urandom_range(0, 199) == 0);
      host_wen   = 1'($urandom_range(0, 1));
      core_wen   = 1'($urandom_range(0, 1));
      host_addr  = 8'($urandom_range(0, 255));
      host_wdata = 8'($urandom_range(0, 255));
      core_addr  = 8'($urandom_range(0, 255));
      core_wdata = 8'($urandom_range(0, 255));
      tick();
    end
    init = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
